// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and owner IDs.
package dmem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/DFF_RST.sv
// Register primitive with asynchronous active-high reset to a parameterised value.
module DFF_RST #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way picker: fixed priority to the core, or round-robin on ties.
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       rr,
  output logic       winner
);

  always_comb begin
    winner = OWN_CORE;
    if (req == 2'b10)
      winner = OWN_DBG;
    else if (req == 2'b11 && rr)
      winner = ~last_owner;
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter/sequencer for the single data-memory port, one access in flight.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          o_busy
);

  // Handshake: mN_req is held by the requester until its one-cycle mN_gnt; mN_rvalid
  // is a one-cycle pulse carrying mN_rdata; mem_req stays high until mem_gnt.
  state_t        state_d, state_q;
  logic          owner_d, owner_q;
  logic          last_owner_d, last_owner_q;
  logic          we_d, we_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [31:0]   wdata_d, wdata_q;
  logic          winner;

  arb_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner_q),
    .rr         (RR),
    .winner     (winner)
  );

  DFF_RST #(.W(2), .RST_VAL(ST_IDLE)) u_state_q (
    .clk(clk_sys), .rst(rst_sys), .d(state_d), .q(state_q));
  DFF_RST #(.W(1), .RST_VAL(OWN_CORE)) u_owner_q (
    .clk(clk_sys), .rst(rst_sys), .d(owner_d), .q(owner_q));
  // last_owner resets to the debug master so the core wins the first tie.
  DFF_RST #(.W(1), .RST_VAL(OWN_DBG)) u_last_owner_q (
    .clk(clk_sys), .rst(rst_sys), .d(last_owner_d), .q(last_owner_q));
  DFF_RST #(.W(1)) u_we_q (
    .clk(clk_sys), .rst(rst_sys), .d(we_d), .q(we_q));
  DFF_RST #(.W(AW)) u_addr_q (
    .clk(clk_sys), .rst(rst_sys), .d(addr_d), .q(addr_q));
  DFF_RST #(.W(32)) u_wdata_q (
    .clk(clk_sys), .rst(rst_sys), .d(wdata_d), .q(wdata_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (m0_req || m1_req) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt)          state_d = ST_RESP;
      ST_RESP: if (mem_rvalid)       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Payload is captured only at arbitration; later requester changes are ignored.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (state_q == ST_IDLE && (m0_req || m1_req)) begin
      owner_d = winner;
      we_d    = (winner == OWN_DBG) ? m1_we    : m0_we;
      addr_d  = (winner == OWN_DBG) ? m1_addr  : m0_addr;
      wdata_d = (winner == OWN_DBG) ? m1_wdata : m0_wdata;
    end
    if (state_q == ST_REQ && mem_gnt)
      last_owner_d = owner_q;
  end

  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    o_busy    = (state_q != ST_IDLE);
    m0_gnt    = mem_req && mem_gnt && (owner_q == OWN_CORE);
    m1_gnt    = mem_req && mem_gnt && (owner_q == OWN_DBG);
    m0_rvalid = (state_q == ST_RESP) && mem_rvalid && (owner_q == OWN_CORE);
    m1_rvalid = (state_q == ST_RESP) && mem_rvalid && (owner_q == OWN_DBG);
    m0_rdata  = m0_rvalid ? mem_rdata : 32'd0;
    m1_rdata  = m1_rvalid ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: a round-robin and a fixed-priority instance share stimulus.
module tb_dmem_arb;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_req, mem_we, o_busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_gnt_f, m0_rvalid_f, m1_gnt_f, m1_rvalid_f, mem_req_f, mem_we_f, o_busy_f;
  logic [31:0] m0_rdata_f, m1_rdata_f, mem_addr_f, mem_wdata_f;

  int checks = 0;
  int failures = 0;

  // Expected grant one-hot {m1,m0} and response {rvalid1,rvalid0,rdata1,rdata0}.
  logic [1:0]  exp_gnt_q[$];
  logic [65:0] exp_q[$];
  logic [1:0]  expf_gnt_q[$];
  logic [65:0] expf_q[$];

  always #5 clk_sys = ~clk_sys;

  dmem_arb #(.AW(32), .RR(1'b1)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_busy(o_busy));

  dmem_arb #(.AW(32), .RR(1'b0)) dut_f (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_f), .m0_rvalid(m0_rvalid_f), .m0_rdata(m0_rdata_f),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_f), .m1_rvalid(m1_rvalid_f), .m1_rdata(m1_rdata_f),
    .mem_req(mem_req_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_busy(o_busy_f));

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [65:0] mk_rsp(input logic owner, input logic [31:0] data);
    mk_rsp = owner ? {2'b10, data, 32'd0} : {2'b01, 32'd0, data};
  endfunction

  // Driver helpers: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_gnt(input logic own_rr, input logic own_f);
    exp_gnt_q.push_back(own_rr ? 2'b10 : 2'b01);
    expf_gnt_q.push_back(own_f ? 2'b10 : 2'b01);
  endtask

  task automatic push_rsp(input logic own_rr, input logic own_f, input logic [31:0] data);
    exp_q.push_back(mk_rsp(own_rr, data));
    expf_q.push_back(mk_rsp(own_f, data));
  endtask

  // Monitor: pops an expectation whenever either instance presents a gnt or rvalid.
  always @(negedge clk_sys) begin
    logic [1:0]  eg;
    logic [65:0] er;
    if (!rst_sys) begin
      if (m0_gnt || m1_gnt) begin
        chk1("rr_gnt_expected", exp_gnt_q.size() != 0, 1'b1);
        if (exp_gnt_q.size() != 0) begin
          eg = exp_gnt_q.pop_front();
          chk1("rr_gnt_m0", m0_gnt, eg[0]);
          chk1("rr_gnt_m1", m1_gnt, eg[1]);
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        chk1("rr_rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          chk1("rr_rvalid_m0", m0_rvalid, er[64]);
          chk1("rr_rvalid_m1", m1_rvalid, er[65]);
          chk32("rr_rdata_m0", m0_rdata, er[31:0]);
          chk32("rr_rdata_m1", m1_rdata, er[63:32]);
        end
      end
      if (m0_gnt_f || m1_gnt_f) begin
        chk1("fp_gnt_expected", expf_gnt_q.size() != 0, 1'b1);
        if (expf_gnt_q.size() != 0) begin
          eg = expf_gnt_q.pop_front();
          chk1("fp_gnt_m0", m0_gnt_f, eg[0]);
          chk1("fp_gnt_m1", m1_gnt_f, eg[1]);
        end
      end
      if (m0_rvalid_f || m1_rvalid_f) begin
        chk1("fp_rsp_expected", expf_q.size() != 0, 1'b1);
        if (expf_q.size() != 0) begin
          er = expf_q.pop_front();
          chk1("fp_rvalid_m0", m0_rvalid_f, er[64]);
          chk1("fp_rvalid_m1", m1_rvalid_f, er[65]);
          chk32("fp_rdata_m0", m0_rdata_f, er[31:0]);
          chk32("fp_rdata_m1", m1_rdata_f, er[63:32]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs must be 0 even with memory and requesters active.
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF; m0_req = 1; m1_req = 1;
    cyc(); cyc(); #3;
    chk1("rst_mem_req", mem_req, 0);
    chk1("rst_busy", o_busy, 0);
    chk1("rst_gnt", m0_gnt | m1_gnt, 0);
    chk1("rst_rvalid", m0_rvalid | m1_rvalid, 0);
    chk32("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; m0_req = 0; m1_req = 0;
    cyc(); rst_sys = 0;
    cyc();

    // Single core read at 0x100, immediate gnt and response.
    cyc(); m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    push_gnt(0, 0); push_rsp(0, 0, 32'hDEAD_BEEF);
    #3 chk1("t1_idle_mem_req", mem_req, 0);
    cyc(); mem_gnt = 1;
    #3 chk1("t1_mem_req", mem_req, 1); chk32("t1_mem_addr", mem_addr, 32'h100);
    chk1("t1_mem_we", mem_we, 0); chk1("t1_m0_gnt", m0_gnt, 1);
    cyc(); mem_gnt = 0; m0_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #3 chk1("t1_resp_mem_req", mem_req, 0); chk1("t1_m0_rvalid", m0_rvalid, 1);
    chk32("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc(); mem_rvalid = 0; mem_rdata = 0;
    #3 chk1("t1_busy_done", o_busy, 0);

    // Core write with gnt delayed 3 cycles: payload must stay stable.
    cyc(); m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1234_5678;
    push_gnt(0, 0); push_rsp(0, 0, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_gnt = (i == 3);
      #3 chk1("t2_mem_req", mem_req, 1); chk1("t2_mem_we", mem_we, 1);
      chk32("t2_mem_addr", mem_addr, 32'h20); chk32("t2_mem_wdata", mem_wdata, 32'h1234_5678);
      chk1("t2_m0_gnt", m0_gnt, i == 3);
    end
    cyc(); mem_gnt = 0; m0_req = 0; m0_we = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_A5A5;
    #3 chk1("t2_m0_rvalid", m0_rvalid, 1);
    cyc(); mem_rvalid = 0; mem_rdata = 0;
    #3 chk1("t2_busy_done", o_busy, 0);

    // Both requesters continuous: RR alternates from m0, fixed priority stays on m0.
    cyc(); rst_sys = 1;
    cyc(); rst_sys = 0;
    cyc(); m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_we = 0; m1_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      push_gnt(k[0], 0); push_rsp(k[0], 0, 32'h1000 + k);
      cyc(); mem_gnt = 1;
      #3 chk32("t3_rr_mem_addr", mem_addr, k[0] ? 32'h80 : 32'h40);
      chk32("t3_fp_mem_addr", mem_addr_f, 32'h40);
      cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + k;
      cyc(); mem_rvalid = 0; mem_rdata = 0;
      if (k == 3) begin m0_req = 0; m1_req = 0; end
    end

    // Spurious memory handshakes in IDLE, REQ and RESP.
    cyc(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
    #3 chk1("t4_idle_busy", o_busy, 0); chk1("t4_idle_gnt", m0_gnt | m1_gnt, 0);
    chk1("t4_idle_rvalid", m0_rvalid | m1_rvalid, 0);
    cyc(); mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #3 chk1("t4_idle_stay", o_busy, 0);
    cyc(); m0_req = 1; m0_addr = 32'h300;
    push_gnt(0, 0); push_rsp(0, 0, 32'h0F0F_0F0F);
    cyc(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    #3 chk1("t4_req_rvalid_ignored", m0_rvalid, 0); chk1("t4_req_gnt", m0_gnt, 1);
    cyc(); mem_rvalid = 0; m0_req = 0;
    #3 chk1("t4_resp_gnt_ignored", m0_gnt, 0); chk1("t4_resp_busy", o_busy, 1);
    chk1("t4_resp_mem_req", mem_req, 0);
    cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0F0F_0F0F;
    #3 chk1("t4_m0_rvalid", m0_rvalid, 1);
    cyc(); mem_rvalid = 0; mem_rdata = 0;
    #3 chk1("t4_busy_done", o_busy, 0);

    // Reset in RESP; late memory response must be ignored.
    cyc(); m1_req = 1; m1_addr = 32'h600;
    push_gnt(1, 1);
    cyc(); mem_gnt = 1;
    cyc(); mem_gnt = 0; m1_req = 0;
    #3 chk1("t5_resp_busy", o_busy, 1);
    rst_sys = 1;
    #1 chk1("t5_rst_busy", o_busy, 0); chk1("t5_rst_mem_req", mem_req, 0);
    chk1("t5_rst_rvalid", m1_rvalid, 0);
    cyc(); rst_sys = 0;
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0077;
    #3 chk1("t5_late_rvalid", m1_rvalid | m0_rvalid, 0); chk1("t5_late_busy", o_busy, 0);
    cyc(); mem_rvalid = 0; mem_rdata = 0;

    // m1 drops req and scrambles its address before gnt; transaction still completes.
    cyc(); m1_req = 1; m1_we = 0; m1_addr = 32'h500;
    push_gnt(1, 1); push_rsp(1, 1, 32'hCAFE_F00D);
    cyc(); m1_req = 0; m1_addr = 32'hFFF;
    #3 chk32("t6_mem_addr", mem_addr, 32'h500); chk1("t6_mem_req", mem_req, 1);
    cyc(); mem_gnt = 1;
    #3 chk1("t6_m1_gnt", m1_gnt, 1); chk32("t6_mem_addr_held", mem_addr, 32'h500);
    cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #3 chk1("t6_m1_rvalid", m1_rvalid, 1); chk32("t6_m1_rdata", m1_rdata, 32'hCAFE_F00D);
    chk32("t6_m0_rdata", m0_rdata, 32'd0);
    cyc(); mem_rvalid = 0; mem_rdata = 0;
    #3 chk1("t6_busy_done", o_busy, 0);

    cyc(); cyc(); #3;
    chk32("rr_gnt_q_empty", exp_gnt_q.size(), 32'd0);
    chk32("rr_rsp_q_empty", exp_q.size(), 32'd0);
    chk32("fp_gnt_q_empty", expf_gnt_q.size(), 32'd0);
    chk32("fp_rsp_q_empty", expf_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Two-requester arbiter and sequencer for the single data-memory port.
- Requester 0 is the core memory-access stage (the mem wen/ren/addr/wdata signals toward data mem). Requester 1 is a debug/DMA master.
- Serialises accesses with one transaction outstanding, drives the memory request/grant/response handshake, and routes responses back to the owning requester.
- Sits between the MEM pipeline stage and the data-memory macro or bus bridge.

Parameters:
- AW, 32, address width of requesters and memory.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 winning.

Ports:
- clk_sys  in  1  system clock.
- rst_sys  in  1  reset, asynchronous, active-high.
- m0_req  in  1  core request; held until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  core address.
- m0_wdata  in  32  core write data.
- m0_gnt  out  1  one-cycle pulse: request accepted by memory.
- m0_rvalid  out  1  one-cycle pulse: response for core (read data or write ack).
- m0_rdata  out  32  read data, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for debug/DMA.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  32  memory read data.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-high. Every output is 0 during reset.
  - FSM = IDLE, owner = 0, last_owner = 1 (requester 0 wins the first tie), payload registers = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any mN_req = 1: pick a winner.
    - RR = 0: requester 0 has priority.
    - RR = 1: the requester not equal to last_owner wins a tie; a lone requester always wins.
  - Register owner and the winner's we/addr/wdata, then go to REQ.
- REQ:
  - mem_req = 1; mem_we, mem_addr and mem_wdata come from the payload registers (registered, glitch-free).
  - On mem_gnt = 1: pulse m{owner}_gnt combinationally in the same cycle, set last_owner = owner, go to RESP.
  - Otherwise hold REQ with a stable payload.
- RESP:
  - mem_req = 0.
  - On mem_rvalid = 1: m{owner}_rvalid = 1 and m{owner}_rdata = mem_rdata, both combinational; go to IDLE.
  - The non-owner's rvalid stays 0 and its rdata stays 0.
- Writes also complete with mem_rvalid; the write ack carries don't-care rdata, forwarded unchanged.
- Minimum latency, request at cycle N with memory answering immediately:
  - mem_req at N+1; mem_gnt at N+1 gives mN_gnt at N+1.
  - mem_rvalid at N+2 gives mN_rvalid at N+2.
  - Back in IDLE at N+3, where the next arbitration happens.
  - Back-to-back throughput is one access per 3 cycles minimum.
- The requester must hold req and payload until gnt. The arbiter samples the payload at arbitration, so changes after that are ignored.
- A requester that drops req before gnt does not cancel the transaction: it completes and the response is still routed to it.
- mem_gnt in IDLE or RESP, or mem_rvalid in IDLE or REQ: ignored, no state change.
- Simultaneous mem_gnt and mem_rvalid in REQ: gnt is honoured, rvalid is ignored (single outstanding).
- Fairness: with both requesters asserting continuously and RR = 1, grants strictly alternate.
- o_busy = (state != IDLE).
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and mem_req drops asynchronously. A response from memory after reset is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2;
  - owner IDs OWN_CORE = 1'b0, OWN_DBG = 1'b1.
- Registers are built from the existing DFF_RST primitive.
- One natural sub-module: arb_pick2, a combinational 2-way picker with inputs req[1:0], last_owner and RR, and output winner.

Test Plan:
- Single core read at 0x100, memory grants at once and returns 0xDEADBEEF the next cycle:
  - mem_req high cycles 1-1, m0_gnt at cycle 1, m0_rvalid with m0_rdata = 0xDEADBEEF at cycle 2, o_busy low at cycle 3.
- Core write of addr 0x20, data 0x12345678, memory delays gnt 3 cycles:
  - mem_req held 4 cycles with mem_we = 1 and a stable payload.
  - m0_gnt is a single pulse; m1_* stay 0 throughout.
- Both requesters asserting continuously, RR = 1, 4 transactions:
  - grant order m0, m1, m0, m1.
  - Same stimulus with RR = 0: grant order m0, m0, m0, m0.
- Spurious mem_rvalid while in IDLE, and mem_gnt while in RESP:
  - no m*_gnt or m*_rvalid pulse, state unchanged.
- rst_sys asserted in RESP with mem_rvalid arriving 1 cycle after reset release:
  - mem_req = 0 and o_busy = 0 immediately; m*_rvalid stays 0.
- m1 drops req one cycle after arbitration, before gnt:
  - the transaction still completes; m1_gnt and m1_rvalid still pulse with the correct rdata.
